// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage of a five-stage MIPS pipeline.
//
// The stage holds the register file and selects each source operand from
// the E/M forwarding paths, the write-back port or the array. Branches and
// jumps resolve here. A load still pending in E stalls any instruction that
// reads its destination. The ID/EX register is a one-entry valid/ready
// buffer.
//
// Handshake rules, on both sides: a transfer happens on a rising edge where
// valid && ready. The input side accepts only when there is no stall and
// the output slot is empty or is draining this cycle.
//
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   in_valid/in_ready              IF/ID handshake
//   in_ir, in_pc4                  instruction word and its PC+4
//   w_we, w_addr, w_data           register-file write-back port
//   fe_*, fm_*                     E- and M-stage forwarding sources
//   e_pend, e_pend_addr            E-stage result not yet available
//   out_valid/out_ready            ID/EX handshake
//   out_ir..out_imm                registered decode bundle
//   redirect, redirect_pc          taken control transfer (combinational)
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc4,
  input  logic            w_we,
  input  logic [AW-1:0]   w_addr,
  input  logic [XLEN-1:0] w_data,
  input  logic            fe_valid,
  input  logic [AW-1:0]   fe_addr,
  input  logic [XLEN-1:0] fe_data,
  input  logic            fm_valid,
  input  logic [AW-1:0]   fm_addr,
  input  logic [XLEN-1:0] fm_data,
  input  logic            e_pend,
  input  logic [AW-1:0]   e_pend_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc4,
  output logic [XLEN-1:0] out_rs,
  output logic [XLEN-1:0] out_rt,
  output logic [XLEN-1:0] out_imm,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  logic [XLEN-1:0] rf_q [NREG];

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [4:0]      rs_f;
  logic [4:0]      rt_f;
  logic [AW-1:0]   rs_a;
  logic [AW-1:0]   rt_a;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] target;
  logic            taken;
  logic            reads_rs;
  logic            reads_rt;
  logic            stall;
  logic            fire;

  logic            out_valid_q;
  logic [31:0]     out_ir_q;
  logic [XLEN-1:0] out_pc4_q;
  logic [XLEN-1:0] out_rs_q;
  logic [XLEN-1:0] out_rt_q;
  logic [XLEN-1:0] out_imm_q;

  assign op    = in_ir[31:26];
  assign funct = in_ir[5:0];
  assign rs_f  = in_ir[25:21];
  assign rt_f  = in_ir[20:16];
  assign rs_a  = rs_f[AW-1:0];
  assign rt_a  = rt_f[AW-1:0];

  // Youngest producer wins: E, then M, then the value being written back.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic [AW-1:0]   a,
    input logic [XLEN-1:0] arr_val
  );
    if (a == '0)                                   return '0;
    else if (fe_valid && fe_addr == a)             return fe_data;
    else if (fm_valid && fm_addr == a)             return fm_data;
    else if ((BYPASS != 0) && w_we && w_addr == a) return w_data;
    else                                           return arr_val;
  endfunction

  always_comb begin
    rs_val = pick_operand(rs_a, rf_q[rs_a]);
    rt_val = pick_operand(rt_a, rf_q[rt_a]);
  end

  // Source usage decides which pending load must hold the instruction back.
  always_comb begin
    reads_rs = !(op == 6'h02 || op == 6'h03 || op == 6'h0f);
    reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
               (op >= 6'h28 && op <= 6'h2b);
    stall    = e_pend && (e_pend_addr != '0) &&
               ((reads_rs && e_pend_addr == rs_a) ||
                (reads_rt && e_pend_addr == rt_a));
  end

  always_comb begin
    imm_sext = {{(XLEN-16){in_ir[15]}}, in_ir[15:0]};
    if (op >= 6'h0c && op <= 6'h0e)
      imm_d = {{(XLEN-16){1'b0}}, in_ir[15:0]};
    else if (op == 6'h0f)
      imm_d = {{(XLEN-32){1'b0}}, in_ir[15:0], 16'h0000};
    else
      imm_d = imm_sext;
  end

  // Branch conditions use the forwarded operands, so no external flags.
  always_comb begin
    taken  = 1'b0;
    target = in_pc4 + {imm_sext[XLEN-3:0], 2'b00};
    unique case (op)
      6'h00: if (funct == 6'h08) begin
               taken  = 1'b1;
               target = rs_val;
             end
      6'h01: begin
               if (rt_f == 5'd0)      taken = rs_val[XLEN-1];
               else if (rt_f == 5'd1) taken = !rs_val[XLEN-1];
             end
      6'h02, 6'h03: begin
               taken  = 1'b1;
               target = {in_pc4[XLEN-1:28], in_ir[25:0], 2'b00};
             end
      6'h04: taken = (rs_val == rt_val);
      6'h05: taken = (rs_val != rt_val);
      6'h06: taken = rs_val[XLEN-1] || (rs_val == '0);
      6'h07: taken = !rs_val[XLEN-1] && (rs_val != '0);
      default: taken = 1'b0;
    endcase
  end

  // reset gates in_ready, so fire and redirect are also quiet in reset.
  assign in_ready    = reset && !stall && (!out_valid_q || out_ready);
  assign fire        = in_valid && in_ready;
  assign redirect    = fire && taken;
  assign redirect_pc = redirect ? target : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (w_we && w_addr != '0) begin
      rf_q[w_addr] <= w_data;
    end
  end

  // When nothing fires but the consumer is taking the current entry, the
  // slot empties; the stale bundle is left in place as a don't-care.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_ir_q    <= '0;
      out_pc4_q   <= '0;
      out_rs_q    <= '0;
      out_rt_q    <= '0;
      out_imm_q   <= '0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_ir_q    <= in_ir;
      out_pc4_q   <= in_pc4;
      out_rs_q    <= rs_val;
      out_rt_q    <= rt_val;
      out_imm_q   <= imm_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ir    = out_ir_q;
  assign out_pc4   = out_pc4_q;
  assign out_rs    = out_rs_q;
  assign out_rt    = out_rt_q;
  assign out_imm   = out_imm_q;

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the five-stage MIPS pipeline: integrated register file, E/M/W operand forwarding, in-stage branch/jump resolution, load-use stall detection, and a registered ID/EX output with valid/ready handshakes. Sits between the IF/ID latch and the execute stage. It replaces external zero/gzero/lzero flags with internal comparison and adds back-pressure and stall handling.

## Interface
- XLEN, 32: data/PC width; must be ≥ 32.
- NREG, 32: register count; power of two. AW = log2(NREG). Only IR address bits [AW-1:0] of each 5-bit field are used.
- BYPASS, 1: 1 = register-file write-through in the same cycle; 0 = no write-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  instruction accepted this cycle.
- in_ir  in  32  instruction word.
- in_pc4  in  XLEN  PC+4 of the instruction.
- w_we, w_addr[AW], w_data[XLEN]  in  write-back port.
- fe_valid, fe_addr[AW], fe_data[XLEN]  in  E-stage forward source.
- fm_valid, fm_addr[AW], fm_data[XLEN]  in  M-stage forward source.
- e_pend, e_pend_addr[AW]  in  E-stage result not yet available (load in E).
- out_valid  out  1  ID/EX register valid.
- out_ready  in  1  execute stage accepts.
- out_ir[32], out_pc4[XLEN], out_rs[XLEN], out_rt[XLEN], out_imm[XLEN]  out  registered bundle.
- redirect  out  1  taken branch/jump resolved this cycle.
- redirect_pc  out  XLEN  target PC.

## Operation
- Register file: NREG×XLEN. Writes on clk when w_we=1 and w_addr≠0. Register 0 always reads 0. Reset clears all registers.
- Operand select for rs, rt, each independently. Address 0 → 0. Otherwise priority is fe (valid and address match) > fm > write-back (BYPASS=1, w_we, match) > array.
- Stall: asserted when e_pend=1, e_pend_addr≠0, and e_pend_addr equals a source the instruction reads.
  - rs is read by all except j/jal/lui.
  - rt is read by R-type, beq/bne, and stores (op 0x28–0x2b).
- in_ready = !stall && (!out_valid || out_ready).
- Fire = in_valid && in_ready. On fire, the ID/EX register loads the bundle and out_valid goes to 1.
- If not fired and out_ready=1, out_valid goes to 0 (bubble). If not fired and out_ready=0, the bundle holds.
- Immediate:
  - Zero-extend for andi/ori/xori (0x0c–0x0e).
  - lui (0x0f): imm<<16, upper bits 0.
  - Sign-extend otherwise.
- Control flow, evaluated on forwarded operands:
  - beq 0x04: rs==rt.
  - bne 0x05: rs≠rt.
  - blez 0x06: signed rs≤0.
  - bgtz 0x07: signed rs>0.
  - op 0x01 with rt=0 (bltz): signed rs<0.
  - op 0x01 with rt=1 (bgez): signed rs≥0.
  - Branch target = in_pc4 + (sext(imm)<<2), modulo 2^XLEN.
  - j 0x02 / jal 0x03: always taken; target = {in_pc4[XLEN-1:28], ir[25:0], 2'b00}.
  - jr (op 0, funct 0x08): always taken; target = rs.
- redirect = fire && taken (combinational). redirect_pc is valid only when redirect=1 and is 0 otherwise.
  - A stalled or back-pressured branch never redirects. It redirects exactly once, on the cycle it fires.

## Timing
- Reset (reset=0 at an edge):
  - out_valid=0, all out_* = 0, all registers 0.
  - in_ready and redirect are forced 0 while reset=0.
- Decode latency: 1 cycle from fire to out_valid.
- Write-back then read: a write at edge N is visible to a read at cycle N+1 via the array. With BYPASS=1 it is also visible in cycle N.
- Stall releases in the cycle e_pend drops. The forwarded value comes from fe/fm in that same cycle.
- Simultaneous stall and out_ready=1: a bubble is inserted and the bundle contents are don't-care except out_valid=0.
- Reset asserted mid-stall or mid-hold discards the held bundle.

## Test plan
- Reset → out_valid=0, redirect=0. Then ori $3,$0,0x8001 (0x34038001) fires → next cycle out_imm=0x00008001, out_valid=1.
- w_we=1, w_addr=5, w_data=0xDEADBEEF while add $1,$5,$0 is decoded, BYPASS=1 → out_rs=0xDEADBEEF. Same stimulus with fe_valid, fe_addr=5, fe_data=0x11 → out_rs=0x11.
- e_pend=1, e_pend_addr=2, instruction beq $2,$3,+4 → in_ready=0, redirect=0, bubble issued. Next cycle: e_pend=0, fm supplies $2=$3=7 → fire, redirect=1, redirect_pc=in_pc4+16.
- out_ready=0 for 3 cycles with out_valid=1 → bundle is stable, in_ready=0. Then out_ready=1 → next instruction accepted.
- jr $31 with $31=0x00400020 → redirect_pc=0x00400020. bltz with rs=0x80000000 → taken. bgtz with rs=0 → not taken.
- Write to $0 with 0xFFFFFFFF → subsequent rs=$0 reads 0.
